branch_resolver: RTL

BRANCH_RESOLVER -- requirements
Module: branch_resolver

---
 rtl/bp_pkg.sv | 13 +
 rtl/pred_fifo.sv | 52 +++++
 rtl/branch_resolver.sv | 90 +++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared sizing for the branch resolver: default queue depth, counter width
// and the occupancy width derived from a depth.
package bp_pkg;

    function automatic int bp_occ_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int BP_DEPTH = 4;
    localparam int BP_CNT_W = 8;
    localparam int BP_OCC_W = bp_occ_w(BP_DEPTH);

endpackage

// File: rtl/pred_fifo.sv
// In-order queue of in-flight branch predictions. Clear empties the queue at
// the edge and overrides any same-cycle push or pop.
module pred_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = BP_DEPTH
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_push,
    input  logic i_pop,
    input  logic i_clear,
    input  logic i_din,
    output logic o_head,
    output logic o_full,
    output logic o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = bp_occ_w(DEPTH);

    logic             r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_occ;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({i_push, i_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Storage is never reset; pointers alone define validity.
    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_din;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_occ == OCC_W'(DEPTH));
    assign o_empty = (r_occ == '0);

endmodule

// File: rtl/branch_resolver.sv
// Matches resolving branches against queued predictions, pulses predictor
// update / flush strobes one cycle later and keeps saturating statistics.
module branch_resolver
    import bp_pkg::*;
#(
    parameter int DEPTH = BP_DEPTH,
    parameter int CNT_W = BP_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_pred_valid,
    input  logic             i_pred_bit,
    input  logic             i_res_valid,
    input  logic             i_res_taken,
    output logic             o_upd_valid,
    output logic             o_taken,
    output logic             o_mispredict,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_branch_cnt,
    output logic [CNT_W-1:0] o_mispred_cnt,
    output logic             o_err
);

    logic w_head;
    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;
    logic w_mis;
    logic w_overflow;
    logic w_underflow;

    logic             r_upd_valid;
    logic             r_taken;
    logic             r_mispredict;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;
    logic             r_err;

    assign w_pop       = i_res_valid && !w_empty;
    assign w_push      = i_pred_valid && (!w_full || w_pop);
    assign w_mis       = w_pop && (w_head != i_res_taken);
    assign w_overflow  = i_pred_valid && w_full && !w_pop;
    assign w_underflow = i_res_valid && w_empty;

    pred_fifo #(
        .DEPTH (DEPTH)
    ) u_pred_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (w_mis),
        .i_din   (i_pred_bit),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_upd_valid   <= 1'b0;
            r_taken       <= 1'b0;
            r_mispredict  <= 1'b0;
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
            r_err         <= 1'b0;
        end else begin
            r_upd_valid  <= w_pop;
            r_mispredict <= w_mis;
            if (w_pop) r_taken <= i_res_taken;
            if (w_pop && (r_branch_cnt != '1))
                r_branch_cnt <= r_branch_cnt + CNT_W'(1);
            if (w_mis && (r_mispred_cnt != '1))
                r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
            if (w_overflow || w_underflow) r_err <= 1'b1;
        end
    end

    assign o_upd_valid   = r_upd_valid;
    assign o_taken       = r_taken;
    assign o_mispredict  = r_mispredict;
    assign o_full        = w_full;
    assign o_empty       = w_empty;
    assign o_branch_cnt  = r_branch_cnt;
    assign o_mispred_cnt = r_mispred_cnt;
    assign o_err         = r_err;

endmodule
